hyper_uart_tx: RTL and testbench

Serial output stage for the calculator's HyperTerminal path. It paces the calculator with one-cycle `senddata` strobes and captures each character the calculator marks for the terminal into a small FIFO. It then serialises the characters as 8N1 (optionally 8E1) UART frames on `TX`. It sits directly downstream of the calculator FSM, in parallel with the LCD writer that consumes `lcddata`.

---
 rtl/hyper_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_hyper_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_uart_tx.sv
// hyper_uart_tx: paces the calculator with senddata strobes, captures terminal
// characters into a small FIFO and shifts them out as 8N1 UART frames on TX.
// Define HYPER_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module hyper_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4,
  parameter int GAP_CLKS     = 4
) (
  input  logic               USER_CLK,
  input  logic               RESET_N,
  input  logic [7:0]         data,
  input  logic               ready,
  input  logic               itishyper,
  output logic               senddata,
  output logic               TX,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int BW         = $clog2(CLKS_PER_BIT);
  localparam int GW         = $clog2(GAP_CLKS + 1);
  localparam int GAP_LAST_I = (GAP_CLKS > 2) ? GAP_CLKS - 3 : 0;

  localparam logic [BW-1:0]        BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0]        GAP_LAST  = GW'(GAP_LAST_I);
  localparam logic [FIFO_AW+1:0]   DEPTH_W   = (FIFO_AW+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STROBE, CAPTURE, GAP} req_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  req_state_t          req_state;
  tx_state_t           tx_state;
  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [GW-1:0]       gap_cnt;
  logic [BW-1:0]       baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift_reg;
  logic                push;
  logic                pop;
  logic                baud_end;
  logic                room;

  // Only the cycle right after a strobe may capture a character, and only a terminal one.
  assign push     = (req_state == CAPTURE) && ready && itishyper;
  assign baud_end = (baud_cnt == BAUD_LAST);
  // The head is taken either from idle or on the last stop-bit cycle so frames run back to back.
  assign pop      = (fifo_count != '0) &&
                    ((tx_state == T_IDLE) || ((tx_state == T_STOP) && baud_end));
  // Free-slot test includes a push landing this cycle, so a strobe never overfills the FIFO.
  assign room     = ({1'b0, fifo_count} + (FIFO_AW+2)'(push)) < DEPTH_W;

  // Request pacing: the end of the gap evaluates the idle condition in the same cycle,
  // which keeps strobes exactly GAP_CLKS apart while there is room; IDLE is where it stalls when full.
  always_ff @(posedge USER_CLK) begin
    if (!RESET_N) begin
      req_state <= IDLE;
      senddata  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      senddata <= 1'b0;
      case (req_state)
        IDLE: begin
          if (room) begin
            req_state <= STROBE;
            senddata  <= 1'b1;
          end
        end
        STROBE: req_state <= CAPTURE;
        CAPTURE: begin
          gap_cnt <= '0;
          if (GAP_CLKS > 2) begin
            req_state <= GAP;
          end else if (room) begin
            req_state <= STROBE;
            senddata  <= 1'b1;
          end else begin
            req_state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (room) begin
              req_state <= STROBE;
              senddata  <= 1'b1;
            end else begin
              req_state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: req_state <= IDLE;
      endcase
    end
  end

  // Character FIFO: pointers wrap modulo depth, occupancy tracks pushes minus pops.
  always_ff @(posedge USER_CLK) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + (FIFO_AW+1)'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - (FIFO_AW+1)'(1);
      end
    end
  end

  // UART serialiser: start, eight data bits LSB first, optional parity, stop; TX and busy are registered.
  always_ff @(posedge USER_CLK) begin
    if (!RESET_N) begin
      tx_state  <= T_IDLE;
      TX        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            tx_state  <= T_START;
            TX        <= 1'b0;
            busy      <= 1'b1;
            baud_cnt  <= '0;
          end
        end
        T_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_state <= T_DATA;
            TX       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        T_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef HYPER_UART_TX_PARITY_EN
              tx_state <= T_PAR;
              TX       <= ^shift_reg;
`else
              tx_state <= T_STOP;
              TX       <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TX      <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`ifdef HYPER_UART_TX_PARITY_EN
        T_PAR: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_state <= T_STOP;
            TX       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
`endif
        T_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              tx_state  <= T_START;
              TX        <= 1'b0;
            end else begin
              tx_state <= T_IDLE;
              busy     <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx_state <= T_IDLE;
          TX       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_uart_tx.sv
// tb_hyper_uart_tx: randomized calculator model feeding hyper_uart_tx, with a
// UART line receiver popping expected characters from a scoreboard queue.
`timescale 1ns/1ps
module tb_hyper_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int GAP   = 4;
  localparam int DEPTH = 1 << AW;
`ifdef HYPER_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          USER_CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          ready = 1'b0;
  logic          itishyper = 1'b0;
  logic          senddata;
  logic          TX;
  logic          busy;
  logic [AW:0]   fifo_count;

  int         n_vectors = 0;
  int         n_miscompares = 0;
  int         cyc = 0;
  int         mode = 0;
  bit         exact_gap = 1'b0;
  bit         single_pending = 1'b0;
  logic [7:0] single_val = 8'h00;
  int         single_cap_cyc = 0;
  int         strobe_count = 0;
  bit         strobe_prev = 1'b0;
  int         last_strobe = -1;
  bit         rx_abort = 1'b0;
  logic [7:0] exp_q[$];

  hyper_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(AW),
    .GAP_CLKS(GAP)
  ) dut (
    .USER_CLK(USER_CLK),
    .RESET_N(RESET_N),
    .data(data),
    .ready(ready),
    .itishyper(itishyper),
    .senddata(senddata),
    .TX(TX),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 USER_CLK = ~USER_CLK;

  always @(posedge USER_CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Calculator model: drives inputs every cycle; the cycle after a strobe is the capture window.
  task automatic applyStimulus();
    bit in_capture;
    in_capture  = strobe_prev;
    strobe_prev = (senddata === 1'b1);
    case (mode)
      1: begin
        ready     = 1'($urandom_range(0, 1));
        itishyper = ($urandom_range(0, 3) != 0);
        data      = 8'($urandom);
      end
      2: begin
        ready     = 1'b1;
        itishyper = 1'b1;
        data      = 8'($urandom);
      end
      3: begin
        ready     = 1'b1;
        itishyper = 1'b0;
        data      = in_capture ? 8'hC0 : 8'($urandom);
      end
      default: begin
        ready     = 1'b0;
        itishyper = 1'($urandom_range(0, 1));
        data      = 8'($urandom);
      end
    endcase
    if (in_capture && single_pending) begin
      ready          = 1'b1;
      itishyper      = 1'b1;
      data           = single_val;
      single_pending = 1'b0;
      single_cap_cyc = cyc;
    end
    if (in_capture && ready && itishyper) exp_q.push_back(data);
  endtask

  // Stimulus driver plus strobe-protocol checks.
  initial begin : driver
    forever begin
      @(negedge USER_CLK);
      if (!RESET_N) begin
        strobe_prev = 1'b0;
        last_strobe = -1;
        ready       = 1'b0;
        itishyper   = 1'b0;
      end else begin
        if (senddata === 1'b1) begin
          strobe_count++;
          checkOutput("strobe_with_room", int'(fifo_count < DEPTH), 1);
          checkOutput("strobe_single_cycle", int'(strobe_prev), 0);
          if (last_strobe >= 0) begin
            if (exact_gap) checkOutput("strobe_spacing", cyc - last_strobe, GAP);
            else checkOutput("strobe_min_spacing", int'((cyc - last_strobe) >= GAP), 1);
          end
          last_strobe = cyc;
        end
        applyStimulus();
      end
    end
  end

  task automatic rx_wait(input int n);
    repeat (n) begin
      @(negedge USER_CLK);
      if (!RESET_N) rx_abort = 1'b1;
    end
  endtask

  // Line receiver: samples each bit mid-way and scores the decoded byte against the queue head.
  initial begin : rx_monitor
    logic [7:0] rx_byte;
    logic [7:0] want;
    logic       stop_bit;
    logic       par_bit;
    par_bit = 1'b0;
    forever begin
      @(negedge USER_CLK);
      if (RESET_N && TX === 1'b0) begin
        rx_abort = 1'b0;
        checkOutput("busy_at_start", int'(busy), 1);
        rx_wait(CPB / 2);
        if (!rx_abort) checkOutput("start_bit", int'(TX), 0);
        for (int k = 0; k < 8; k++) begin
          rx_wait(CPB);
          rx_byte[k] = TX;
        end
`ifdef HYPER_UART_TX_PARITY_EN
        rx_wait(CPB);
        par_bit = TX;
`endif
        rx_wait(CPB);
        stop_bit = TX;
        rx_wait(CPB - CPB / 2 - 1);
        if (!rx_abort) begin
          checkOutput("stop_bit", int'(stop_bit), 1);
          checkOutput("busy_last_stop", int'(busy), 1);
          checkOutput("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checkOutput("rx_byte", int'(rx_byte), int'(want));
`ifdef HYPER_UART_TX_PARITY_EN
            checkOutput("parity_bit", int'(par_bit), int'(^want));
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed phase sequencing; random data flows through the driver and receiver throughout.
  initial begin : main
    int n;
    RESET_N = 1'b0;
    mode    = 0;
    repeat (3) @(negedge USER_CLK);
    checkOutput("reset_senddata", int'(senddata), 0);
    checkOutput("reset_tx", int'(TX), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_count", int'(fifo_count), 0);

    // Idle pacing with ready low.
    exact_gap    = 1'b1;
    strobe_count = 0;
    RESET_N      = 1'b1;
    repeat (40) begin
      @(negedge USER_CLK);
      checkOutput("idle_tx", int'(TX), 1);
      checkOutput("idle_count", int'(fifo_count), 0);
    end
    checkOutput("idle_strobe_count", int'(strobe_count >= 9), 1);
    exact_gap = 1'b0;

    // Single character 0x35: latency from capture and frame length.
    single_val     = 8'h35;
    single_pending = 1'b1;
    n = 0;
    while (single_pending && n < 50) begin
      @(negedge USER_CLK);
      n++;
    end
    checkOutput("single_captured", int'(single_pending), 0);
    while (cyc < single_cap_cyc + 1) @(negedge USER_CLK);
    checkOutput("pop_cycle_tx", int'(TX), 1);
    checkOutput("pop_cycle_busy", int'(busy), 0);
    @(negedge USER_CLK);
    checkOutput("start_edge_tx", int'(TX), 0);
    checkOutput("start_edge_busy", int'(busy), 1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge USER_CLK);
    end
    checkOutput("busy_length", n, NBITS * CPB);
    checkOutput("single_drained", exp_q.size(), 0);

    // LCD-only characters: nothing is queued or sent.
    mode = 3;
    repeat (60) begin
      @(negedge USER_CLK);
      checkOutput("lcd_only_count", int'(fifo_count), 0);
      checkOutput("lcd_only_tx", int'(TX), 1);
    end

    // Continuous ready: fill the FIFO, then strobes must resume after a pop.
    mode = 2;
    n = 0;
    while (fifo_count != DEPTH && n < 600) begin
      @(negedge USER_CLK);
      n++;
    end
    checkOutput("fifo_fills", int'(fifo_count), DEPTH);
    n = 0;
    while (fifo_count == DEPTH && n < 200) begin
      @(negedge USER_CLK);
      checkOutput("stall_no_strobe", int'(senddata), 0);
      n++;
    end
    n = 0;
    while (senddata !== 1'b1 && n < 6) begin
      @(negedge USER_CLK);
      n++;
    end
    checkOutput("strobe_resumes", int'(senddata), 1);
    repeat (300) begin
      @(negedge USER_CLK);
      checkOutput("count_bound", int'(fifo_count <= DEPTH), 1);
    end

    // Random calculator traffic.
    mode = 1;
    repeat (400) @(negedge USER_CLK);

    // Drain everything.
    mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 0) && n < 3000) begin
      @(negedge USER_CLK);
      n++;
    end
    checkOutput("drained", int'(exp_q.size() == 0 && !busy && fifo_count == 0), 1);

    // 'T' frame exercises the parity bit when enabled.
    single_val     = 8'h54;
    single_pending = 1'b1;
    n = 0;
    while ((single_pending || busy || exp_q.size() != 0) && n < 200) begin
      @(negedge USER_CLK);
      n++;
    end
    checkOutput("t_frame_done", int'(exp_q.size()), 0);

    // Reset in the middle of a frame with a loaded FIFO.
    mode = 2;
    repeat (60) @(negedge USER_CLK);
    repeat (7) @(negedge USER_CLK);
    checkOutput("pre_reset_busy", int'(busy), 1);
    mode    = 0;
    RESET_N = 1'b0;
    @(negedge USER_CLK);
    checkOutput("midreset_tx", int'(TX), 1);
    checkOutput("midreset_count", int'(fifo_count), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_senddata", int'(senddata), 0);
    repeat (2) @(negedge USER_CLK);
    exp_q.delete();
    RESET_N = 1'b1;
    repeat (80) begin
      @(negedge USER_CLK);
      checkOutput("post_reset_tx", int'(TX), 1);
      checkOutput("post_reset_count", int'(fifo_count), 0);
    end
    checkOutput("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
